// File: rtl/option_record_assembler.sv
// Assembles one framed option-pricing record (SYNC, 28 payload bytes, XOR checksum)
// from a byte stream and presents it to the BRAM writer through a one-entry valid/ready buffer.
//
// state   | meaning
// HUNT    | discarding bytes until SYNC_BYTE
// PAYLOAD | shifting in the 28 payload bytes
// CHECK   | next strobe carries the checksum; a good frame commits here
module option_record_assembler #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         CNT_W          = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [127:0]     newData,
  output logic [31:0]      volatility,
  output logic [31:0]      otype,
  output logic [31:0]      timet,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  // Abort on the edge where the idle count would reach TIMEOUT_CYCLES.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]        LAST_IDX  = 5'd27;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [223:0]      asm_q, asm_d;
  logic [223:0]      rec_q, rec_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  frame_q, frame_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic good;
  logic err_ev;
  logic accept;
  logic commit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= HUNT;
      idx_q   <= '0;
      csum_q  <= '0;
      idle_q  <= '0;
      asm_q   <= '0;
      rec_q   <= '0;
      valid_q <= 1'b0;
      frame_q <= '0;
      err_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      idle_q  <= idle_d;
      asm_q   <= asm_d;
      rec_q   <= rec_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    idle_d  = idle_q;
    asm_d   = asm_q;
    rec_d   = rec_q;
    valid_d = valid_q;
    frame_d = frame_q;
    err_d   = err_q;
    drop_d  = drop_q;
    good    = 1'b0;
    err_ev  = 1'b0;
    accept  = valid_q & rec_ready;

    case (state_q)
      HUNT: begin
        idx_d  = '0;
        csum_d = '0;
        idle_d = '0;
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          asm_d  = {asm_q[215:0], rx_data};
          csum_d = csum_q ^ rx_data;
          idle_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = CHECK;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end else if (idle_q == IDLE_LAST) begin
          err_ev  = 1'b1;
          idle_d  = '0;
          state_d = HUNT;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      CHECK: begin
        if (rx_valid) begin
          idle_d  = '0;
          state_d = HUNT;
          if (rx_data == csum_q) begin
            good = 1'b1;
          end else begin
            err_ev = 1'b1;
          end
        end else if (idle_q == IDLE_LAST) begin
          err_ev  = 1'b1;
          idle_d  = '0;
          state_d = HUNT;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      default: begin
        state_d = HUNT;
        idx_d   = '0;
        csum_d  = '0;
        idle_d  = '0;
      end
    endcase

    // A same-cycle accept frees the buffer, so the new record follows without a bubble.
    commit = good & (~valid_q | accept);
    if (commit) begin
      rec_d   = asm_q;
      valid_d = 1'b1;
      frame_d = sat_inc(frame_q);
    end else begin
      if (good) begin
        drop_d = sat_inc(drop_q);
      end
      if (accept) begin
        valid_d = 1'b0;
      end
    end

    if (err_ev) begin
      err_d = sat_inc(err_q);
    end
  end

  assign rec_valid  = valid_q;
  assign newData    = rec_q[223:96];
  assign volatility = rec_q[95:64];
  assign otype      = rec_q[63:32];
  assign timet      = rec_q[31:0];
  assign frame_cnt  = frame_q;
  assign err_cnt    = err_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_option_record_assembler.sv
// Bench for option_record_assembler: frame-level reference model with a per-cycle compare,
// directed scenarios with literal expectations, then randomized framing/handshake traffic.
module tb_option_record_assembler;

  localparam int TO = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         rec_ready = 1'b0;
  logic         rec_valid;
  logic [127:0] newData;
  logic [31:0]  volatility, otype, timet;
  logic [7:0]   frame_cnt, err_cnt, drop_cnt;

  always #5 clock = ~clock;

  option_record_assembler #(
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rec_valid(rec_valid),
    .rec_ready(rec_ready),
    .newData(newData),
    .volatility(volatility),
    .otype(otype),
    .timet(timet),
    .frame_cnt(frame_cnt),
    .err_cnt(err_cnt),
    .drop_cnt(drop_cnt)
  );

  int n_chk = 0;
  int n_err = 0;
  bit rnd_rdy = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Reference model: collects the bytes of a frame in a queue and judges it once complete.
  bit          m_in;
  logic [7:0]  m_q[$];
  int          m_idle;
  bit          m_valid;
  logic [223:0] m_rec;
  int          m_frame, m_err, m_drop;
  bit          m_good, m_acc;
  logic [7:0]  m_x;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_in = 0; m_q.delete(); m_idle = 0; m_valid = 0; m_rec = '0;
      m_frame = 0; m_err = 0; m_drop = 0;
    end else begin
      m_good = 0;
      m_acc  = m_valid && rec_ready;
      if (!m_in) begin
        if (rx_valid && rx_data == 8'hA5) begin
          m_in = 1; m_q.delete(); m_idle = 0;
        end
      end else if (rx_valid) begin
        m_idle = 0;
        m_q.push_back(rx_data);
        if (m_q.size() == 29) begin
          m_x = 8'h00;
          for (int i = 0; i < 28; i++) m_x ^= m_q[i];
          if (m_x == m_q[28]) m_good = 1;
          else if (m_err < 255) m_err++;
          m_in = 0;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          if (m_err < 255) m_err++;
          m_in = 0; m_idle = 0;
        end
      end
      if (m_good && (!m_valid || m_acc)) begin
        for (int i = 0; i < 28; i++) m_rec[223-8*i -: 8] = m_q[i];
        m_valid = 1;
        if (m_frame < 255) m_frame++;
      end else begin
        if (m_good && m_drop < 255) m_drop++;
        if (m_acc) m_valid = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("cyc_rec_valid", rec_valid, m_valid);
      chk("cyc_frame_cnt", frame_cnt, m_frame[7:0]);
      chk("cyc_err_cnt", err_cnt, m_err[7:0]);
      chk("cyc_drop_cnt", drop_cnt, m_drop[7:0]);
      if (m_valid) begin
        chk("cyc_newData", newData, m_rec[223:96]);
        chk("cyc_volatility", volatility, m_rec[95:64]);
        chk("cyc_otype", otype, m_rec[63:32]);
        chk("cyc_timet", timet, m_rec[31:0]);
      end
    end
  end

  logic [7:0] pl[28];

  function automatic logic [7:0] pl_csum();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 28; i++) x ^= pl[i];
    return x;
  endfunction

  task automatic fill_seq(input logic [7:0] base);
    for (int i = 0; i < 28; i++) pl[i] = base + 8'(i);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (rnd_rdy) rec_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_payload(input int maxgap, input int tmo_at);
    send_byte(8'hA5);
    for (int i = 0; i < 28; i++) begin
      send_byte(pl[i]);
      if (i == tmo_at) idle_cycles(TO + 2);
      else if (maxgap > 0) idle_cycles($urandom_range(0, maxgap));
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rec_ready = 1'b0;
    rx_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #5_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: basic decode and latency
    do_reset();
    chk("rst_rec_valid", rec_valid, 1'b0);
    chk("rst_newData", newData, 128'h0);
    chk("rst_timet", timet, 32'h0);
    chk("rst_counters", {frame_cnt, err_cnt, drop_cnt}, 24'h0);
    fill_seq(8'h01);
    send_payload(0, -1);
    chk("t1_pre_valid", rec_valid, 1'b0);
    send_byte(8'h1C);
    chk("t1_valid", rec_valid, 1'b1);
    chk("t1_newData", newData, 128'h0102030405060708090A0B0C0D0E0F10);
    chk("t1_volatility", volatility, 32'h11121314);
    chk("t1_otype", otype, 32'h15161718);
    chk("t1_timet", timet, 32'h191A1B1C);
    chk("t1_frame_cnt", frame_cnt, 8'd1);
    chk("t1_model_newData", m_rec[223:96], 128'h0102030405060708090A0B0C0D0E0F10);
    chk("t1_model_timet", m_rec[31:0], 32'h191A1B1C);

    // 2: bad checksum, then recovery
    do_reset();
    send_payload(0, -1);
    send_byte(8'hE3);
    chk("t2_valid", rec_valid, 1'b0);
    chk("t2_err_cnt", err_cnt, 8'd1);
    chk("t2_model_err", m_err, 1);
    send_payload(0, -1);
    send_byte(8'h1C);
    chk("t2_frame_cnt", frame_cnt, 8'd1);
    chk("t2_valid_after", rec_valid, 1'b1);

    // 3: buffer full drops the second frame
    do_reset();
    fill_seq(8'h01);
    send_payload(0, -1);
    send_byte(pl_csum());
    fill_seq(8'h40);
    send_payload(0, -1);
    send_byte(pl_csum());
    chk("t3_held_data", newData, 128'h0102030405060708090A0B0C0D0E0F10);
    chk("t3_drop_cnt", drop_cnt, 8'd1);
    chk("t3_frame_cnt", frame_cnt, 8'd1);
    chk("t3_model_drop", m_drop, 1);
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
    chk("t3_valid_cleared", rec_valid, 1'b0);

    // 4: accept and commit on the same edge
    do_reset();
    fill_seq(8'h01);
    send_payload(0, -1);
    send_byte(pl_csum());
    fill_seq(8'h80);
    send_payload(0, -1);
    rx_valid  = 1'b1;
    rx_data   = pl_csum();
    rec_ready = 1'b1;
    chk("t4_pre_valid", rec_valid, 1'b1);
    tick();
    rx_valid  = 1'b0;
    rec_ready = 1'b0;
    chk("t4_valid_kept", rec_valid, 1'b1);
    chk("t4_newData", newData, 128'h808182838485868788898A8B8C8D8E8F);
    chk("t4_timet", timet, 32'h989A9B9B & 32'h00000000 | 32'h98999A9B);
    chk("t4_frame_cnt", frame_cnt, 8'd2);
    chk("t4_drop_cnt", drop_cnt, 8'd0);

    // 5: timeout inside a frame
    do_reset();
    send_byte(8'hA5);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h30 + i));
    idle_cycles(TO - 1);
    chk("t5_err_before", err_cnt, 8'd0);
    tick();
    chk("t5_err_at_timeout", err_cnt, 8'd1);
    idle_cycles(3);
    fill_seq(8'h01);
    send_payload(0, -1);
    send_byte(pl_csum());
    chk("t5_newData", newData, 128'h0102030405060708090A0B0C0D0E0F10);
    chk("t5_frame_cnt", frame_cnt, 8'd1);
    chk("t5_err_final", err_cnt, 8'd1);

    // 6: noise, SYNC value as payload data, then asynchronous reset mid-frame
    do_reset();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    fill_seq(8'h01);
    pl[4] = 8'hA5;
    send_payload(0, -1);
    send_byte(pl_csum());
    chk("t6_newData", newData, 128'h01020304A5060708090A0B0C0D0E0F10);
    chk("t6_err_cnt", err_cnt, 8'd0);
    chk("t6_frame_cnt", frame_cnt, 8'd1);
    send_byte(8'hA5);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h60 + i));
    #3 reset = 1'b0;
    #1;
    chk("t6_rst_valid", rec_valid, 1'b0);
    chk("t6_rst_data", {newData, volatility, otype, timet} == '0, 1'b1);
    chk("t6_rst_counters", {frame_cnt, err_cnt, drop_cnt}, 24'h0);
    @(posedge clock);
    #1 reset = 1'b1;
    tick();

    // 7: error counter saturation
    do_reset();
    fill_seq(8'h03);
    repeat (260) begin
      send_payload(0, -1);
      send_byte(~pl_csum());
    end
    chk("t7_err_sat", err_cnt, 8'hFF);
    chk("t7_frame_cnt", frame_cnt, 8'd0);

    // 8: randomized traffic against the model
    do_reset();
    rnd_rdy = 1'b1;
    repeat (150) begin
      logic [7:0] nb;
      int n_noise;
      n_noise = $urandom_range(0, 2);
      for (int k = 0; k < n_noise; k++) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == 8'hA5) nb = 8'h00;
        send_byte(nb);
      end
      for (int i = 0; i < 28; i++) pl[i] = 8'($urandom_range(0, 255));
      send_payload(2, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 27)) : -1);
      send_byte(($urandom_range(0, 4) == 0) ? ~pl_csum() : pl_csum());
      idle_cycles($urandom_range(0, 3));
    end
    rnd_rdy = 1'b0;
    rec_ready = 1'b0;
    idle_cycles(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
